linked_list_queue_mgr: RTL
==========================

# linked_list_queue_mgr

Multi-queue FIFO in which FIFOS logical queues share one DEPTH-entry storage pool through a linked list of entry pointers plus a free list. It is the next generation of our shared-pool FIFO: it generalises depth, width and queue count, and adds four things. A hardware free-list initialiser, a per-queue occupancy cap, per-queue single-cycle flush that splices a whole queue back onto the free list, and a registered output with valid strobe. It sits between packet classifiers and per-channel consumers wherever per-channel buffering must share one RAM.

## Interface
Parameters
- WIDTH, 8: data width in bits.
- DEPTH, 32: total shared entries; power of two, at least 4.
- FIFOS, 8: number of logical queues; power of two, at least 2.
- MAX_PER_FIFO, DEPTH: occupancy cap per queue, 1..DEPTH.
- AF_THRESH, 4: almost_full asserts when free_count <= AF_THRESH.
- Derived: LW = clog2(DEPTH), CW = LW+1, FW = clog2(FIFOS).

Ports
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low; deassertion is synchronised externally.
- push  in  1  enqueue d onto queue push_fifo.
- push_fifo  in  FW  target queue for push.
- d  in  WIDTH  push data.
- pop  in  1  dequeue the head of queue pop_fifo.
- pop_fifo  in  FW  source queue for pop.
- flush  in  1  discard the whole contents of queue flush_fifo.
- flush_fifo  in  FW  target queue for flush.
- q  out  WIDTH  popped data, registered.
- q_valid  out  1  q holds the data of the pop issued the previous cycle.
- ready  out  1  initialisation is done; commands are accepted.
- empty  out  FIFOS  per-queue empty bitmap.
- fifo_full  out  FIFOS  per-queue flag; bit set when that queue's count == MAX_PER_FIFO.
- full  out  1  free_count == 0.
- almost_full  out  1  free_count <= AF_THRESH.
- free_count  out  CW  number of free entries, 0..DEPTH.
- count  out  FIFOS*CW  per-queue occupancy; queue i occupies bits [i*CW +: CW].
- error  out  1  sticky illegal-command flag.

## Operation
- Storage:
  - data RAM, DEPTH x WIDTH;
  - link RAM, DEPTH x LW, read combinationally;
  - per queue: head, tail and count;
  - free list: free_head, free_tail and free_count.
- State machine INIT -> RUN.
  - INIT: a counter i steps 0..DEPTH-1 and writes link[i] = i+1; the wrap of the last write is don't-care.
  - Leaving INIT: free_head = 0, free_tail = DEPTH-1, free_count = DEPTH, then go to RUN and set ready = 1.
  - In INIT, all commands are ignored and do not set error.
- Push (accepted when ready, !full, !fifo_full[push_fifo] and no flush):
  - Allocate entry e = free_head, write data[e] = d, advance free_head = link[e].
  - If the queue is empty: head = tail = e. Otherwise: link[tail] = e, tail = e.
  - count increments and free_count decrements.
- Pop (accepted when ready, !empty[pop_fifo] and no flush):
  - Entry e = head; register q = data[e]; head = link[e].
  - Return e to the free list: link[free_tail] = e, free_tail = e. If the free list was empty, free_head = e.
  - count decrements and free_count increments.
- Push and pop in the same cycle:
  - Different queues: both are performed.
  - Same non-empty queue: both are performed and count is unchanged.
  - Same empty queue: the push is performed and the pop is rejected.
  - A pop never frees an entry for a push in the same cycle, so a push while full is rejected.
- Flush (accepted when ready; flush on an empty queue is a no-op):
  - Splice: link[free_tail] = head[f], free_tail = tail[f], free_count += count[f].
  - If free_count was 0, free_head = head[f] instead.
  - Then count[f] = 0.
  - In a flush cycle, any push or pop is rejected, whichever queue it targets.
- Rejected commands leave all state unchanged and set error. error clears only on reset.
- Reset asserted mid-operation: all state clears at once and the block re-enters INIT. Queue contents are lost.

## Timing
- Reset values:
  - q = 0, q_valid = 0, ready = 0;
  - empty = all ones, fifo_full = 0, count = 0;
  - full = 1, free_count = 0, almost_full = 1;
  - error = 0.
- INIT lasts DEPTH cycles after reset deassertion. On the following edge: ready = 1, free_count = DEPTH, full = 0.
- Push:
  - count, empty, free_count, full and almost_full update on the accepting edge;
  - the data is poppable from the next cycle.
- Pop: q and q_valid are registered on the accepting edge. q_valid stays high for one cycle per accepted pop; q holds its value otherwise.
- Flush: all flags are updated by the edge that ends the flush cycle.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- Reset, then wait 32 cycles: ready rises at cycle 32, free_count = 32, empty = 8'hFF.
- Push 5, 6 to queue 0, then pop twice: q = 5 then 6, each with q_valid one cycle after its pop; count[0] returns to 0.
- Fill queue 1 until full (32 pushes, MAX_PER_FIFO = 32), then push once more: full = 1, the extra push is dropped, error = 1.
- Push 10 entries to queue 2 and 3 to queue 3, then flush queue 2: free_count goes 19 -> 29. Queue 3 then pops its three values in order.
- Simultaneous pop of queue 4 and push to queue 4 while count[4] = 3 for 10 cycles: count stays 3 and the data sequence is preserved.
- Random push/pop/flush on all queues for 10^6 cycles against a per-queue behavioural model: q matches on every q_valid, and no error occurs when legality is respected.

Source files
------------

// File: rtl/linked_list_queue_mgr.sv
// linked_list_queue_mgr
//   FIFOS logical queues sharing one DEPTH-entry storage pool. Each queue is a
//   singly linked chain through the link RAM. Unused entries form a free list.
//   A hardware initialiser builds the free list after reset. Queues support a
//   single-cycle flush that splices the whole chain back onto the free list.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   push, push_fifo, d      enqueue d onto queue push_fifo
//   pop, pop_fifo           dequeue head of queue pop_fifo -> q/q_valid next cycle
//   flush, flush_fifo       drop the whole contents of queue flush_fifo
//   q, q_valid              registered pop data and strobe
//   ready                   initialisation complete
//   empty, fifo_full        per-queue flags
//   full, almost_full       pool flags derived from free_count
//   free_count              free entries, 0..DEPTH
//   count                   per-queue occupancy, queue i at [i*CW +: CW]
//   error                   sticky: a push or pop was rejected
//
// state | meaning
// INIT  | writing link[i] = i+1 to chain every entry into the free list
// RUN   | free list valid, commands accepted
module linked_list_queue_mgr #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 32,
  parameter int FIFOS        = 8,
  parameter int MAX_PER_FIFO = DEPTH,
  parameter int AF_THRESH    = 4,
  localparam int LW = $clog2(DEPTH),
  localparam int CW = LW + 1,
  localparam int FW = $clog2(FIFOS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [FW-1:0]       push_fifo,
  input  logic [WIDTH-1:0]    d,
  input  logic                pop,
  input  logic [FW-1:0]       pop_fifo,
  input  logic                flush,
  input  logic [FW-1:0]       flush_fifo,
  output logic [WIDTH-1:0]    q,
  output logic                q_valid,
  output logic                ready,
  output logic [FIFOS-1:0]    empty,
  output logic [FIFOS-1:0]    fifo_full,
  output logic                full,
  output logic                almost_full,
  output logic [CW-1:0]       free_count,
  output logic [FIFOS*CW-1:0] count,
  output logic                error
);

  localparam logic [CW-1:0] MAX_C   = CW'(MAX_PER_FIFO);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [LW-1:0] LAST_IX = LW'(DEPTH - 1);

  typedef enum logic [0:0] {INIT, RUN} state_t;

  state_t           state;
  logic [LW-1:0]    init_idx;
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [LW-1:0]    link_mem [DEPTH];
  logic [LW-1:0]    head     [FIFOS];
  logic [LW-1:0]    tail     [FIFOS];
  logic [CW-1:0]    cnt      [FIFOS];
  logic [LW-1:0]    free_head, free_tail;
  logic [CW-1:0]    free_cnt;

  logic          push_ok, pop_ok, flush_ok, same_q;
  logic [LW-1:0] push_e, pop_e;

  assign push_ok  = ready && push && !flush && (free_cnt != '0) && (cnt[push_fifo] != MAX_C);
  assign pop_ok   = ready && pop && !flush && (cnt[pop_fifo] != '0);
  assign flush_ok = ready && flush && (cnt[flush_fifo] != '0);
  assign same_q   = (push_fifo == pop_fifo);
  assign push_e   = free_head;
  assign pop_e    = head[pop_fifo];

  always_ff @(posedge clk) begin
    if (push_ok) data_mem[push_e] <= d;
  end

  // When the free list is empty free_tail is stale and may name a live entry,
  // so appends to the free list only write a link when the list is non-empty.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      link_mem[init_idx] <= init_idx + 1'b1;
    end else begin
      if (flush_ok && free_cnt != '0) link_mem[free_tail] <= head[flush_fifo];
      if (push_ok && cnt[push_fifo] != '0) link_mem[tail[push_fifo]] <= push_e;
      if (pop_ok && free_cnt != '0) link_mem[free_tail] <= pop_e;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      init_idx  <= '0;
      ready     <= 1'b0;
      free_head <= '0;
      free_tail <= '0;
      free_cnt  <= '0;
      q         <= '0;
      q_valid   <= 1'b0;
      error     <= 1'b0;
      for (int i = 0; i < FIFOS; i++) begin
        head[i] <= '0;
        tail[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      case (state)
        INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == LAST_IX) begin
            free_head <= '0;
            free_tail <= LAST_IX;
            free_cnt  <= CW'(DEPTH);
            ready     <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          q_valid <= pop_ok;
          if (pop_ok) q <= data_mem[pop_e];
          if ((push && !push_ok) || (pop && !pop_ok)) error <= 1'b1;

          if (flush_ok) begin
            if (free_cnt == '0) free_head <= head[flush_fifo];
            free_tail           <= tail[flush_fifo];
            free_cnt            <= free_cnt + cnt[flush_fifo];
            cnt[flush_fifo]     <= '0;
          end else begin
            // With one free entry left, a simultaneous push consumes it and the
            // popped entry becomes the only free entry.
            if (push_ok)
              free_head <= (pop_ok && free_cnt == CW'(1)) ? pop_e : link_mem[free_head];
            else if (pop_ok && free_cnt == '0)
              free_head <= pop_e;
            if (pop_ok) free_tail <= pop_e;
            if (push_ok && !pop_ok) free_cnt <= free_cnt - CW'(1);
            if (pop_ok && !push_ok) free_cnt <= free_cnt + CW'(1);

            if (pop_ok) begin
              head[pop_fifo] <= link_mem[pop_e];
              cnt[pop_fifo]  <= cnt[pop_fifo] - CW'(1);
            end
            if (push_ok) begin
              // A queue drained by the same-cycle pop restarts at the new entry.
              if (cnt[push_fifo] == '0 || (pop_ok && same_q && cnt[push_fifo] == CW'(1)))
                head[push_fifo] <= push_e;
              tail[push_fifo] <= push_e;
              cnt[push_fifo]  <= (pop_ok && same_q) ? cnt[push_fifo] : cnt[push_fifo] + CW'(1);
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  always_comb begin
    empty     = '0;
    fifo_full = '0;
    count     = '0;
    for (int i = 0; i < FIFOS; i++) begin
      empty[i]            = (cnt[i] == '0);
      fifo_full[i]        = (cnt[i] == MAX_C);
      count[i*CW +: CW]   = cnt[i];
    end
  end

  assign free_count  = free_cnt;
  assign full        = (free_cnt == '0);
  assign almost_full = (free_cnt <= AF_C);

endmodule
